// File: rtl/config_frame_writer.sv
// Config frame writer: bitstream word stream in, FrameData/FrameStrobe out.
// Sync, header parse, then a framed strobe with setup/hold around it.
module config_frame_writer #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 8,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
  parameter int          StrobeCycles    = 1
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [31:0]                           WriteData,
  input  logic                                  WriteStrobe,
  output logic                                  Ready,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  Synced,
  output logic                                  Error,
  output logic [15:0]                           FramesWritten
);

  localparam int StrobeW = NumColumns * MaxFramesPerCol;

  typedef enum logic [2:0] {
    UNSYNC,
    HDR,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t             state;
  logic [7:0]         colReg;
  logic [7:0]         frameReg;
  logic               skip;
  logic [3:0]         strobeCnt;
  logic [StrobeW-1:0] strobeSel;

  logic       accept;
  logic [3:0] opcode;
  logic [7:0] hdrCol;
  logic [7:0] hdrFrame;
  logic       inRange;
  logic       hdrGood;
  logic       hdrBad;
  logic       opDesync;
  logic       opNop;
  logic       unusedBits;

  assign Ready    = (state == UNSYNC) || (state == HDR) || (state == DATA);
  assign Synced   = (state != UNSYNC);
  assign accept   = WriteStrobe & Ready;
  assign opcode   = WriteData[31:28];
  assign hdrCol   = WriteData[15:8];
  assign hdrFrame = WriteData[7:0];
  assign inRange  = (hdrCol < 8'(NumColumns))
                 && (hdrFrame < 8'(MaxFramesPerCol));
  assign hdrGood  = (opcode == 4'h1) && inRange;
  assign hdrBad   = (opcode == 4'h1) && !inRange;
  assign opDesync = (opcode == 4'hF);
  assign opNop    = (opcode == 4'h0);
  assign unusedBits = &{1'b0, WriteData[27:16]};

  // One-hot select from the latched column/frame address.
  always_comb begin
    strobeSel = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        strobeSel[c*MaxFramesPerCol+f] = (colReg == 8'(c))
                                      && (frameReg == 8'(f));
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= UNSYNC;
      colReg        <= '0;
      frameReg      <= '0;
      skip          <= 1'b0;
      strobeCnt     <= '0;
      FrameData     <= '0;
      FrameStrobe   <= '0;
      Error         <= 1'b0;
      FramesWritten <= '0;
    end else begin
      unique case (state)
        UNSYNC: begin
          if (accept && (WriteData == SyncWord)) state <= HDR;
        end
        HDR: begin
          if (accept) begin
            unique case (1'b1)
              hdrGood: begin
                colReg   <= hdrCol;
                frameReg <= hdrFrame;
                skip     <= 1'b0;
                state    <= DATA;
              end
              hdrBad: begin
                Error <= 1'b1;
                skip  <= 1'b1;
                state <= DATA;
              end
              opDesync: state <= UNSYNC;
              opNop:    state <= HDR;
              default: begin
                Error <= 1'b1;
                state <= UNSYNC;
              end
            endcase
          end
        end
        DATA: begin
          if (accept) begin
            if (skip) begin
              skip  <= 1'b0;
              state <= HDR;
            end else begin
              FrameData <= FrameBitsPerRow'(WriteData);
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          FrameStrobe <= strobeSel;
          strobeCnt   <= 4'(StrobeCycles - 1);
          if (FramesWritten != 16'hFFFF)
            FramesWritten <= FramesWritten + 16'd1;
          state <= STROBE;
        end
        STROBE: begin
          if (strobeCnt == 4'd0) begin
            FrameStrobe <= '0;
            state       <= HOLD;
          end else begin
            strobeCnt <= strobeCnt - 4'd1;
          end
        end
        HOLD: state <= HDR;
        default: state <= UNSYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer.
// Two instances: default strobe width and a 4-cycle strobe.
module tb_config_frame_writer;

  localparam logic [31:0] Sync = 32'hFAB0_FAB1;

  logic         CLK;
  logic         resetn;
  logic [31:0]  WriteData;
  logic         WriteStrobe;

  logic         ready1, synced1, error1;
  logic [31:0]  data1;
  logic [159:0] strobe1;
  logic [15:0]  count1;

  logic         ready4, synced4, error4;
  logic [31:0]  data4;
  logic [159:0] strobe4;
  logic [15:0]  count4;

  int nChecks = 0;
  int nFail   = 0;

  config_frame_writer dut1 (
    .CLK(CLK), .resetn(resetn),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe),
    .Ready(ready1), .FrameData(data1), .FrameStrobe(strobe1),
    .Synced(synced1), .Error(error1), .FramesWritten(count1)
  );

  config_frame_writer #(.StrobeCycles(4)) dut4 (
    .CLK(CLK), .resetn(resetn),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe),
    .Ready(ready4), .FrameData(data4), .FrameStrobe(strobe4),
    .Synced(synced4), .Error(error4), .FramesWritten(count4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkVal(input string tag,
                          input logic [159:0] got,
                          input logic [159:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    resetn = 1'b0;
    WriteStrobe = 1'b0;
    WriteData = '0;
    @(negedge CLK);
    resetn = 1'b1;
  endtask

  // Offer a word until dut1 takes it; returns 1ns after the accepting edge.
  task automatic putWord(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge CLK);
    WriteData = w;
    WriteStrobe = 1'b1;
    while (!ready1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkVal("readyWait", 160'(n < 50), 160'd1);
    @(posedge CLK);
    #1;
    WriteStrobe = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hiCnt;
    int lowCnt;
    resetn = 1'b1;
    WriteStrobe = 1'b0;
    WriteData = '0;

    // Reset values and sync
    @(negedge CLK);
    resetn = 1'b0;
    #1;
    checkVal("rstSynced", 160'(synced1), 160'd0);
    checkVal("rstError", 160'(error1), 160'd0);
    checkVal("rstData", 160'(data1), 160'd0);
    checkVal("rstStrobe", strobe1, 160'd0);
    checkVal("rstCount", 160'(count1), 160'd0);
    checkVal("rstReady", 160'(ready1), 160'd1);
    @(negedge CLK);
    resetn = 1'b1;
    putWord(32'h1234_5678);
    checkVal("noSync", 160'(synced1), 160'd0);
    putWord(Sync);
    checkVal("synced", 160'(synced1), 160'd1);
    checkVal("syncErr", 160'(error1), 160'd0);

    // Single-cycle frame write to col 2 frame 3
    putWord(32'h1000_0203);
    putWord(32'hDEAD_BEEF);
    checkVal("e0Data", 160'(data1), 160'hDEAD_BEEF);
    checkVal("e0Strobe", strobe1, 160'd0);
    checkVal("e0Ready", 160'(ready1), 160'd0);
    tick();
    checkVal("e1Strobe", strobe1, 160'd1 << 43);
    checkVal("e1Count", 160'(count1), 160'd1);
    checkVal("e1Ready", 160'(ready1), 160'd0);
    tick();
    checkVal("e2Strobe", strobe1, 160'd0);
    checkVal("e2Ready", 160'(ready1), 160'd0);
    checkVal("e2Data", 160'(data1), 160'hDEAD_BEEF);
    tick();
    checkVal("e3Ready", 160'(ready1), 160'd1);
    checkVal("e3Strobe", strobe1, 160'd0);

    // Four-cycle strobe with WriteStrobe held high throughout
    doReset();
    putWord(Sync);
    putWord(32'h1000_0105);
    @(negedge CLK);
    WriteData = 32'hCAFE_0001;
    WriteStrobe = 1'b1;
    tick();
    checkVal("w4Data", 160'(data4), 160'hCAFE_0001);
    hiCnt = 0;
    lowCnt = 0;
    if (strobe4 != 160'd0) hiCnt++;
    if (!ready4) lowCnt++;
    @(negedge CLK);
    WriteData = 32'h1000_0000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (strobe4 == (160'd1 << 25)) hiCnt++;
      else if (strobe4 != 160'd0) hiCnt += 100;
      if (!ready4) lowCnt++;
    end
    checkVal("w4HighCycles", 160'(hiCnt), 160'd4);
    checkVal("w4ReadyLow", 160'(lowCnt), 160'd6);
    checkVal("w4ReadyBack", 160'(ready4), 160'd1);
    tick();
    @(negedge CLK);
    WriteData = 32'h0000_00AA;
    tick();
    WriteStrobe = 1'b0;
    checkVal("w4NextData", 160'(data4), 160'hAA);
    tick();
    checkVal("w4NextStrobe", strobe4, 160'd1);
    checkVal("w4Count", 160'(count4), 160'd2);

    // Out-of-range column: flagged, data skipped
    doReset();
    putWord(Sync);
    putWord(32'h1000_0000);
    putWord(32'h1111_2222);
    putWord(32'h1000_0900);
    checkVal("oorError", 160'(error1), 160'd1);
    putWord(32'hFFFF_FFFF);
    checkVal("oorData", 160'(data1), 160'h1111_2222);
    checkVal("oorReady", 160'(ready1), 160'd1);
    hiCnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (strobe1 != 160'd0) hiCnt++;
      tick();
    end
    checkVal("oorStrobe", 160'(hiCnt), 160'd0);
    checkVal("oorCount", 160'(count1), 160'd1);
    checkVal("oorSynced", 160'(synced1), 160'd1);
    putWord(32'hF000_0000);
    checkVal("desync", 160'(synced1), 160'd0);
    checkVal("desyncErr", 160'(error1), 160'd1);

    // Bad opcode: error, unsync, writes ignored until resync
    doReset();
    putWord(Sync);
    putWord(32'h5000_0000);
    checkVal("badOpErr", 160'(error1), 160'd1);
    checkVal("badOpSync", 160'(synced1), 160'd0);
    putWord(32'h1000_0001);
    putWord(32'h3333_3333);
    tick();
    tick();
    checkVal("ignData", 160'(data1), 160'd0);
    checkVal("ignCount", 160'(count1), 160'd0);
    checkVal("ignStrobe", strobe1, 160'd0);
    putWord(Sync);
    putWord(32'h1000_0001);
    putWord(32'h4444_4444);
    tick();
    checkVal("resyncStrobe", strobe1, 160'd2);
    checkVal("resyncCount", 160'(count1), 160'd1);
    checkVal("stickyErr", 160'(error1), 160'd1);

    // Async reset in the middle of the strobe
    doReset();
    putWord(Sync);
    putWord(32'h1000_0203);
    putWord(32'hDEAD_BEEF);
    tick();
    checkVal("preRstStrobe", strobe1, 160'd1 << 43);
    #2;
    resetn = 1'b0;
    #1;
    checkVal("asyncStrobe", strobe1, 160'd0);
    checkVal("asyncData", 160'(data1), 160'd0);
    checkVal("asyncCount", 160'(count1), 160'd0);
    checkVal("asyncSynced", 160'(synced1), 160'd0);
    checkVal("asyncReady", 160'(ready1), 160'd1);
    @(negedge CLK);
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration-side driver for one fabric row; it is the write end of the FrameData/FrameStrobe interface that tiles buffer and pass through.
- Accepts a 32-bit bitstream word stream over a valid/ready handshake and waits for a sync word.
- Parses frame-write headers, presents each frame word on FrameData, then pulses the one addressed FrameStrobe bit with guaranteed setup and hold around the pulse.
- Sits between the bitstream source (UART/SPI/host loader) and the fabric's top config ports.

Parameters:
- FrameBitsPerRow, 32, width of FrameData; equals bitstream word width.
- MaxFramesPerCol, 20, frames per column; FrameStrobe bits per column.
- NumColumns, 8, columns driven; FrameStrobe is NumColumns*MaxFramesPerCol bits.
- SyncWord, 32'hFAB0_FAB1, word that moves the block from unsynced to synced.
- StrobeCycles, 1, FrameStrobe pulse width in cycles; legal range 1..15.

Ports:
- CLK  input  1  configuration clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- WriteData  input  32  bitstream word.
- WriteStrobe  input  1  WriteData valid.
- Ready  output  1  block accepts a word this cycle; a word transfers when WriteStrobe & Ready.
- FrameData  output  FrameBitsPerRow  frame word to row; registered.
- FrameStrobe  output  NumColumns*MaxFramesPerCol  one-hot write strobes; bit index = col*MaxFramesPerCol + frame; registered.
- Synced  output  1  high in any synced state.
- Error  output  1  sticky protocol error.
- FramesWritten  output  16  count of strobes issued; saturates at 16'hFFFF.

Behaviour:
- Reset (async, resetn=0): state UNSYNC, FrameData=0, FrameStrobe=0, Synced=0, Error=0, FramesWritten=0. A reset during STROBE drops FrameStrobe to 0 immediately, without waiting for a clock.
- Ready = 1 in UNSYNC, HDR and DATA; 0 in SETUP, STROBE and HOLD. Ready is combinational from state only and never depends on WriteStrobe.
- UNSYNC: each accepted word is compared with SyncWord. Match -> HDR. Otherwise the word is discarded; Error is unchanged.
- HDR header fields: [31:28] opcode, [15:8] column, [7:0] frame; other bits are ignored.
  - opcode 4'h1 with column<NumColumns and frame<MaxFramesPerCol -> latch the address, go to DATA.
  - opcode 4'h1 with address out of range -> set Error, go to DATA with a skip flag set.
  - opcode 4'hF (desync) -> UNSYNC.
  - opcode 4'h0 (NOP) -> stay in HDR.
  - any other opcode -> set Error, go to UNSYNC.
- DATA: the accepted word is registered into FrameData at the same edge (edge E0).
  - Skip flag set: FrameData is not updated and no strobe is issued; clear skip, go to HDR.
  - Otherwise go to SETUP.
- SETUP: 1 cycle. FrameData is stable, FrameStrobe=0.
- STROBE: exactly StrobeCycles cycles with the addressed FrameStrobe bit at 1 and all others 0. It starts at edge E0+1. FramesWritten increments once, on entry to STROBE.
- HOLD: 1 cycle. FrameStrobe=0, FrameData is unchanged. Then go to HDR.
- Ready is low for 2+StrobeCycles cycles after each data word.
- FrameData holds its last value indefinitely; it is only rewritten by a valid DATA word.
- A sync word received while in HDR is treated as a header. Its opcode is 4'hF, so it desyncs.
- Error clears only on reset.
- WriteStrobe while Ready=0 is ignored. The word is not consumed; the source must hold it.
- FrameStrobe is never multi-hot, and is never high in the same cycle FrameData changes.

Test Plan:
- Reset, then words 32'h1234_5678 and SyncWord -> Synced=0 after the first word and 1 after SyncWord; Error=0.
- Sync; header 32'h1000_0203; data 32'hDEAD_BEEF -> FrameData=DEAD_BEEF at E0; FrameStrobe bit 2*20+3=43 high only in cycle E0+1; Ready low 3 cycles; FramesWritten=1.
- StrobeCycles=4 with WriteStrobe held high continuously -> bit high for exactly 4 cycles; Ready low 6 cycles; the next header is accepted only afterwards.
- Sync; header 32'h1000_0900 (column 9 ≥ 8); data 32'hFFFF_FFFF -> Error=1, FrameStrobe stays 0, FrameData unchanged, block returns to HDR. Then header 32'hF000_0000 -> Synced=0.
- Header with opcode 4'h5 -> Error=1, Synced=0. A subsequent valid frame write is ignored until SyncWord is seen again.
- resetn pulsed low during the STROBE cycle -> FrameStrobe=0 the same cycle, before any clock edge, and all outputs return to reset values.
